// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// The operation is split into SEG_W-bit lookahead segments, one segment
// resolved per stage, with the segment carry registered between stages.
// Unconsumed operand bits travel forward with the beat and completed sum
// bits accumulate until the last stage, which also forms the flags.
// A single global advance signal stalls the whole pipe under backpressure.
module cla_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NSEG = WIDTH / SEG_W;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             ovf_q;
  logic             zero_q;

  // Flattened sum-of-products lookahead: every carry is built directly from
  // the segment's generate/propagate terms and the segment carry-in, so no
  // carry ripples through the segment.
  function automatic logic [SEG_W:0] cla_carries(input logic [SEG_W-1:0] p,
                                                 input logic [SEG_W-1:0] g,
                                                 input logic             cin);
    logic [SEG_W:0] c;
    logic           term;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SEG_W; i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  // Subtraction is A + ~B + 1; the borrow-in flips the injected carry.
  assign b_eff = in_sub ? ~in_b : in_b;
  assign c0    = in_cin ^ in_sub;

  for (genvar k = 0; k < NSEG; k++) begin : stg
    localparam int LO   = k * SEG_W;
    localparam int DONE = LO + SEG_W;

    logic [WIDTH-LO-1:0] op_a;
    logic [WIDTH-LO-1:0] op_b;
    logic                c_in;
    logic                v_in;
    logic [SEG_W-1:0]    p;
    logic [SEG_W-1:0]    g;
    logic [SEG_W-1:0]    seg_sum;
    logic [SEG_W:0]      c;
    logic [DONE-1:0]     sum_d;
    logic [DONE-1:0]     sum_q;
    logic                c_q;
    logic                v_q;

    if (k == 0) begin : src
      assign op_a  = in_a;
      assign op_b  = b_eff;
      assign c_in  = c0;
      assign v_in  = in_valid;
      assign sum_d = seg_sum;
    end else begin : src
      assign op_a  = stg[k-1].mid.a_q;
      assign op_b  = stg[k-1].mid.b_q;
      assign c_in  = stg[k-1].c_q;
      assign v_in  = stg[k-1].v_q;
      assign sum_d = {seg_sum, stg[k-1].sum_q};
    end

    assign p       = op_a[SEG_W-1:0] ^ op_b[SEG_W-1:0];
    assign g       = op_a[SEG_W-1:0] & op_b[SEG_W-1:0];
    assign c       = cla_carries(p, g, c_in);
    assign seg_sum = p ^ c[SEG_W-1:0];

    // Stage register: valid bit, accumulated sum bits and segment carry-out.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (adv) begin
        v_q   <= v_in;
        sum_q <= sum_d;
        c_q   <= c[SEG_W];
      end
    end

    if (k < NSEG - 1) begin : mid
      logic [WIDTH-DONE-1:0] a_q;
      logic [WIDTH-DONE-1:0] b_q;

      // Carry the not-yet-consumed operand bits forward to later stages.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= op_a[WIDTH-LO-1:SEG_W];
          b_q <= op_b[WIDTH-LO-1:SEG_W];
        end
      end
    end else begin : fin
      // Last stage: signed overflow from the top two carries and zero flag,
      // registered alongside the final sum.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= c[SEG_W] ^ c[SEG_W-1];
          zero_q <= ~|sum_d;
        end
      end
    end
  end

  assign out_valid = stg[NSEG-1].v_q;
  assign out_sum   = stg[NSEG-1].sum_q;
  assign out_cout  = stg[NSEG-1].c_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench for cla_pipe_addsub: a 16/4 instance for directed,
// streaming, backpressure and reset scenarios, plus 8/8, 32/8 and 64/16
// instances for the parameter sweep.
module tb_cla_pipe_addsub;

  logic clk;
  logic rst_n;

  logic        in_valid, in_ready, in_cin, in_sub;
  logic [15:0] in_a, in_b, out_sum;
  logic        out_valid, out_ready, out_cout, out_ovf, out_zero;

  logic        sw_valid, sw_cin, sw_sub;
  logic [63:0] sw_a, sw_b;
  logic        r8, v8, co8, ov8, z8;
  logic [7:0]  s8;
  logic        r32, v32, co32, ov32, z32;
  logic [31:0] s32;
  logic        r64, v64, co64, ov64, z64;
  logic [63:0] s64;

  int checks;
  int errors;

  logic [63:0] sa [1000];
  logic [63:0] sb [1000];
  logic        sc [1000];
  logic        ss [1000];

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  cla_pipe_addsub #(.WIDTH(16), .SEG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero));

  cla_pipe_addsub #(.WIDTH(8), .SEG_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r8),
    .in_a(sw_a[7:0]), .in_b(sw_b[7:0]), .in_cin(sw_cin), .in_sub(sw_sub),
    .out_valid(v8), .out_ready(1'b1), .out_sum(s8),
    .out_cout(co8), .out_ovf(ov8), .out_zero(z8));

  cla_pipe_addsub #(.WIDTH(32), .SEG_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r32),
    .in_a(sw_a[31:0]), .in_b(sw_b[31:0]), .in_cin(sw_cin), .in_sub(sw_sub),
    .out_valid(v32), .out_ready(1'b1), .out_sum(s32),
    .out_cout(co32), .out_ovf(ov32), .out_zero(z32));

  cla_pipe_addsub #(.WIDTH(64), .SEG_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r64),
    .in_a(sw_a), .in_b(sw_b), .in_cin(sw_cin), .in_sub(sw_sub),
    .out_valid(v64), .out_ready(1'b1), .out_sum(s64),
    .out_cout(co64), .out_ovf(ov64), .out_zero(z64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic reference: returns {zero, ovf, cout, sum[63:0]} for width w.
  function automatic logic [66:0] model(input int w, input logic [63:0] a,
                                        input logic [63:0] b, input logic cin,
                                        input logic sub);
    logic [64:0] mask, am, bm, full;
    logic [63:0] s;
    logic        co, ov, z;
    mask = (65'd1 << w) - 65'd1;
    am   = {1'b0, a} & mask;
    bm   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
    full = am + bm + {64'd0, cin ^ sub};
    co   = full[w];
    s    = full[63:0] & mask[63:0];
    ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    z    = (s == 64'd0);
    return {z, ov, co, s};
  endfunction

  // Send one beat into the empty 16-bit pipe and wait (bounded) for its result.
  task automatic run_one(input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub,
                         output logic [18:0] res, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = {out_sum, out_cout, out_ovf, out_zero};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid);
    end
    checks++;
    if ({out_sum, out_cout, out_ovf, out_zero} !== 19'd0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %h want 0", {out_sum, out_cout, out_ovf, out_zero});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_add();
    vec_t tbl [3];
    logic [18:0] res;
    int lat;
    tbl = '{'{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
            '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0},
            '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      run_one(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, res, lat);
      checks++;
      if (res !== {tbl[i].sum, tbl[i].cout, tbl[i].ovf, tbl[i].zero}) begin
        errors++; $display("[TB] FAIL add_%0d: got {sum,c,v,z}=%h want %h", i, res,
                           {tbl[i].sum, tbl[i].cout, tbl[i].ovf, tbl[i].zero});
      end
      checks++;
      if (lat != 4) begin
        errors++; $display("[TB] FAIL add_latency_%0d: got %0d want 4", i, lat);
      end
    end
  endtask

  task automatic test_sub();
    vec_t tbl [4];
    logic [18:0] res;
    int lat;
    tbl = '{'{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0},
            '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0},
            '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0},
            '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1}};
    for (int i = 0; i < 4; i++) begin
      run_one(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, res, lat);
      checks++;
      if (res !== {tbl[i].sum, tbl[i].cout, tbl[i].ovf, tbl[i].zero}) begin
        errors++; $display("[TB] FAIL sub_%0d: got {sum,c,v,z}=%h want %h", i, res,
                           {tbl[i].sum, tbl[i].cout, tbl[i].ovf, tbl[i].zero});
      end
      checks++;
      if (lat != 4) begin
        errors++; $display("[TB] FAIL sub_latency_%0d: got %0d want 4", i, lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [66:0] e;
    int idx;
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    for (int n = 0; n < 104; n++) begin
      @(negedge clk);
      if (n < 100) begin
        sa[n] = {48'd0, 16'($urandom)};
        sb[n] = {48'd0, 16'($urandom)};
        sc[n] = 1'($urandom_range(0, 1));
        ss[n] = 1'($urandom_range(0, 1));
        in_a = sa[n][15:0]; in_b = sb[n][15:0]; in_cin = sc[n]; in_sub = ss[n];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      idx = n - 3;
      checks++;
      if (idx >= 0 && idx < 100) begin
        e = model(16, sa[idx], sb[idx], sc[idx], ss[idx]);
        if ({out_valid, out_zero, out_ovf, out_cout, out_sum} !== {1'b1, e[66:64], e[15:0]}) begin
          errors++; $display("[TB] FAIL stream_%0d: got {v,z,o,c,sum}=%h want %h", idx,
                             {out_valid, out_zero, out_ovf, out_cout, out_sum}, {1'b1, e[66:64], e[15:0]});
        end
      end else if (out_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL stream_bubble_%0d: got out_valid=%b want 0", n, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [18:0] q [$];
    logic [66:0] e;
    logic [19:0] held;
    logic [18:0] front;
    logic        stall;
    int sent, recv;
    sent = 0; recv = 0; stall = 1'b0;
    for (int n = 0; n < 420; n++) begin
      @(negedge clk);
      if (n < 300) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        in_a = 16'($urandom); in_b = 16'($urandom);
        in_cin = 1'($urandom_range(0, 1)); in_sub = 1'($urandom_range(0, 1));
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      if (stall) begin
        checks++;
        if ({out_valid, out_zero, out_ovf, out_cout, out_sum} !== held) begin
          errors++; $display("[TB] FAIL stall_hold: got %h want %h",
                             {out_valid, out_zero, out_ovf, out_cout, out_sum}, held);
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("[TB] FAIL stall_in_ready: got %b want 0", in_ready);
        end
        stall = 1'b1;
        held  = {out_valid, out_zero, out_ovf, out_cout, out_sum};
      end else begin
        stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        recv++;
        if (q.size() == 0) begin
          errors++; $display("[TB] FAIL bp_extra: got result %h want none", out_sum);
        end else begin
          front = q.pop_front();
          if ({out_zero, out_ovf, out_cout, out_sum} !== front) begin
            errors++; $display("[TB] FAIL bp_order: got {z,o,c,sum}=%h want %h",
                               {out_zero, out_ovf, out_cout, out_sum}, front);
          end
        end
      end
      if (in_valid && in_ready) begin
        e = model(16, {48'd0, in_a}, {48'd0, in_b}, in_cin, in_sub);
        q.push_back({e[66:64], e[15:0]});
        sent++;
      end
      @(posedge clk);
    end
    checks++;
    if (q.size() != 0 || recv != sent) begin
      errors++; $display("[TB] FAIL bp_count: got recv=%0d pending=%0d want recv=%0d pending=0",
                         recv, q.size(), sent);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_a = 16'h1111 * 16'(i + 1); in_b = 16'h0101; in_cin = 1'b0; in_sub = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_async: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL midreset_ghost_%0d: got out_valid=%b want 0", n, out_valid);
      end
    end
  endtask

  task automatic test_sweep();
    logic [66:0] e;
    logic [63:0] corner_a [4];
    logic [63:0] corner_b [4];
    int idx;
    corner_a = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h8080_8080_8080_8080, 64'h7F7F_7F7F_7F7F_7F7F};
    corner_b = '{64'h0101_0101_0101_0101, 64'h0, 64'h0101_0101_0101_0101, 64'h7F7F_7F7F_7F7F_7F7F};
    for (int n = 0; n < 1004; n++) begin
      @(negedge clk);
      if (n < 1000) begin
        if (n % 8 < 4) begin
          sa[n] = corner_a[n % 8];
          sb[n] = corner_b[n % 8];
          {ss[n], sc[n]} = 2'((n / 8) % 4);
        end else begin
          sa[n] = {$urandom, $urandom};
          sb[n] = {$urandom, $urandom};
          sc[n] = 1'($urandom_range(0, 1));
          ss[n] = 1'($urandom_range(0, 1));
        end
        sw_a = sa[n]; sw_b = sb[n]; sw_cin = sc[n]; sw_sub = ss[n];
        sw_valid = 1'b1;
      end else begin
        sw_valid = 1'b0;
      end
      @(posedge clk); #1;

      idx = n;
      checks++;
      if (idx < 1000) begin
        e = model(8, sa[idx], sb[idx], sc[idx], ss[idx]);
        if ({r8, v8, z8, ov8, co8, s8} !== {2'b11, e[66:64], e[7:0]}) begin
          errors++; $display("[TB] FAIL sweep8_%0d: got {r,v,z,o,c,sum}=%h want %h", idx,
                             {r8, v8, z8, ov8, co8, s8}, {2'b11, e[66:64], e[7:0]});
        end
      end else if (v8 !== 1'b0) begin
        errors++; $display("[TB] FAIL sweep8_tail_%0d: got v=%b want 0", n, v8);
      end

      idx = n - 3;
      checks++;
      if (idx >= 0 && idx < 1000) begin
        e = model(32, sa[idx], sb[idx], sc[idx], ss[idx]);
        if ({r32, v32, z32, ov32, co32, s32} !== {2'b11, e[66:64], e[31:0]}) begin
          errors++; $display("[TB] FAIL sweep32_%0d: got {r,v,z,o,c,sum}=%h want %h", idx,
                             {r32, v32, z32, ov32, co32, s32}, {2'b11, e[66:64], e[31:0]});
        end
      end else if (v32 !== 1'b0) begin
        errors++; $display("[TB] FAIL sweep32_fill_%0d: got v=%b want 0", n, v32);
      end

      idx = n - 3;
      checks++;
      if (idx >= 0 && idx < 1000) begin
        e = model(64, sa[idx], sb[idx], sc[idx], ss[idx]);
        if ({r64, v64, z64, ov64, co64, s64} !== {2'b11, e[66:64], e[63:0]}) begin
          errors++; $display("[TB] FAIL sweep64_%0d: got {r,v,z,o,c,sum}=%h want %h", idx,
                             {r64, v64, z64, ov64, co64, s64}, {2'b11, e[66:64], e[63:0]});
        end
      end else if (v64 !== 1'b0) begin
        errors++; $display("[TB] FAIL sweep64_fill_%0d: got v=%b want 0", n, v64);
      end
    end
  endtask

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b1;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshaking on both sides. The block splits a WIDTH-bit operation into SEG_W-bit lookahead segments and computes one segment per pipeline stage, with carries registered between stages. It sustains one operation per cycle and provides carry, signed-overflow and zero flags. It is the wide-datapath successor to the team's fixed 8-bit combinational CLA and is intended for ALU and accumulator datapaths.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of SEG_W, and WIDTH ≥ SEG_W.
- SEG_W, 8: lookahead segment width, i.e. bits resolved per pipeline stage. NSEG = WIDTH/SEG_W.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in for add; borrow-in for sub
- in_sub  in  1  0 = A+B+cin; 1 = A−B−cin
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts the result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of the MSB (in sub mode, 1 means no borrow)
- out_ovf  out  1  two's-complement signed overflow
- out_zero  out  1  out_sum == 0

## Operation
- Operand conditioning at accept:
  - b_eff = in_sub ? ~in_b : in_b.
  - c0 = in_cin ^ in_sub. In sub mode, cin=0 gives A−B and cin=1 gives A−B−1.
- Stage k (0..NSEG−1) handles bits [k·SEG_W +: SEG_W]:
  - p = a ^ b_eff and g = a & b_eff.
  - Full lookahead within the segment: each c[i+1] = g[i] | p[i]&c[i], flattened to SOP form and not rippled across the segment.
  - sum = p ^ c.
  - The segment carry-out is registered into stage k+1.
- Skew and deskew:
  - Operand bits above segment k are carried forward in stage registers.
  - Completed lower sum bits are carried forward until the final stage.
- Flags, formed in the last stage:
  - out_cout = c[WIDTH].
  - out_ovf = c[WIDTH] ^ c[WIDTH−1].
  - out_zero is the NOR of the full result and is registered together with it.
- Each stage holds a valid bit. Empty stages are bubbles, and their data registers are don't-care but must not corrupt later beats.
- Flow control:
  - Global advance: adv = !out_valid | out_ready.
  - When adv=1, every stage shifts forward one position and stage 0 loads in_valid plus the operands.
  - When adv=0, all stage registers hold.
- in_ready = adv, a combinational function of out_valid and out_ready. A beat is accepted on in_valid & in_ready.
- Bubbles are not compressed while stalled. This is a simple global stall.
- Reset (asynchronous, any time):
  - All stage valid bits clear and all in-flight beats are discarded.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0.
  - in_ready=1 while reset is asserted and after release.
- NSEG=1 is legal: the block is a single registered CLA stage.

## Timing
- Latency: NSEG cycles from accept edge to out_valid=1. Example: a beat accepted at edge t is presented after edge t+NSEG−1, where NSEG−1 register hops plus the output register give NSEG edges total.
- Throughput: one beat per cycle while out_ready=1.
- Stall: with out_valid=1 and out_ready=0, outputs hold stable and in_ready=0 in the same cycle. On the cycle out_ready rises, the result transfers and the pipeline advances on that edge.
- Ordering: results emerge strictly in accept order with no loss or duplication under any in_valid/out_ready pattern.
- Critical path per stage: one SEG_W-bit lookahead plus the sum XOR. There is no carry path longer than SEG_W bits per cycle.

## Test plan
- Reset check, WIDTH=16, SEG_W=4: hold rst_n=0 → out_valid=0, all outputs 0, in_ready=1. Assert rst_n low mid-stream with 3 beats in flight → no result from those beats ever appears after release.
- Add, WIDTH=16, SEG_W=4: A=0xFFFF, B=0x0001, cin=0, sub=0 → after 4 cycles sum=0x0000, cout=1, ovf=0, zero=1. Also A=0x7FFF, B=0x0001 → sum=0x8000, cout=0, ovf=1, zero=0.
- Subtract: A=0x0005, B=0x0007, sub=1, cin=0 → sum=0xFFFE, cout=0 (borrow). A=0x0007, B=0x0005, sub=1, cin=1 → sum=0x0001, cout=1. A=0x8000, B=0x0001, sub=1, cin=0 → sum=0x7FFF, ovf=1.
- Streaming: 100 back-to-back random beats with out_ready=1 → 100 results in order matching the reference model, one per cycle after the initial 4-cycle fill.
- Backpressure: random in_valid and random out_ready at 50% → no drops, duplicates or reordering. While out_valid & !out_ready, out_sum and the flags stay constant and in_ready=0.
- Parameter sweep: (WIDTH, SEG_W) = (8,8), (32,8), (64,16), each with 1000 random beats including cin/sub corners → all match A±B±cin exactly, and latency equals NSEG.
